// File: rtl/branch_predict_pkg.sv
// Shared types, counter constants and index/tag width helpers
// for the fetch-stage branch predictor.
package branch_predict_pkg;

    localparam int CTR_W_MAX = 4;

    // Fields are sized for the widest legal configuration; upper bits stay zero.
    typedef struct packed {
        logic                 valid;
        logic [31:0]          tag;
        logic [CTR_W_MAX-1:0] ctr;
        logic [31:0]          target;
    } bp_entry_t;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_w(input int pc_w, input int entries);
        return pc_w - $clog2(entries) - 2;
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_max(input int w);
        return CTR_W_MAX'((1 << w) - 1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_weak_t(input int w);
        return CTR_W_MAX'(1 << (w - 1));
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_weak_nt(input int w);
        return CTR_W_MAX'((1 << (w - 1)) - 1);
    endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating-counter next state for one predictor entry.
// Jumps force max; fresh branch allocations start weakly taken.
module sat_counter
    import branch_predict_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             hit_i,
    input  logic             jal_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_o
);

    localparam logic [CTR_W-1:0] MAX  = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] WEAK = CTR_W'(ctr_weak_t(CTR_W));

    always_comb begin
        ctr_o = ctr_i;
        if (jal_i) begin
            ctr_o = MAX;
        end else if (!hit_i) begin
            ctr_o = WEAK;
        end else if (taken_i) begin
            if (ctr_i != MAX) ctr_o = ctr_i + 1'b1;
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor with EX-stage resolution,
// fetch redirect, halt hold and saturating statistics.
module branch_predict_unit
    import branch_predict_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_taken,
    input  logic [31:0]     ex_target,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    input  logic            halt,
    output logic            pc_sel,
    output logic [31:0]     redirect_pc,
    output logic [15:0]     br_count,
    output logic [15:0]     mis_count
);

    localparam int IW = idx_w(ENTRIES);
    localparam logic [CTR_W_MAX-1:0] WEAK_T  = ctr_weak_t(CTR_W);
    localparam logic [CTR_W_MAX-1:0] WEAK_NT = ctr_weak_nt(CTR_W);

    bp_entry_t   tbl_q [ENTRIES];
    bp_entry_t   ent_d;
    logic [15:0] br_q, br_d, mis_q, mis_d;

    logic [IW-1:0]    if_idx, ex_idx;
    logic [31:0]      if_tag, ex_tag, if_pc32, ex_pc32;
    logic             look_hit, ex_hit, resolve, actual, mispred, wr_en;
    logic [CTR_W-1:0] ctr_nxt;

    assign if_idx  = if_pc[IW+1:2];
    assign ex_idx  = ex_pc[IW+1:2];
    assign if_tag  = 32'(if_pc[PC_W-1:IW+2]);
    assign ex_tag  = 32'(ex_pc[PC_W-1:IW+2]);
    assign if_pc32 = 32'(if_pc);
    assign ex_pc32 = 32'(ex_pc);

    // Counter MSB set is equivalent to ctr >= weakly-taken.
    assign look_hit = tbl_q[if_idx].valid
                   && tbl_q[if_idx].tag == if_tag
                   && tbl_q[if_idx].ctr >= WEAK_T;

    assign pred_taken  = !reset && look_hit;
    assign pred_target = pred_taken ? tbl_q[if_idx].target : if_pc32 + 32'd4;

    assign resolve = ex_valid && (ex_branch || ex_jal) && !halt;
    assign actual  = ex_jal || (ex_branch && ex_taken);
    assign mispred = resolve && (actual != ex_pred_taken
                  || (actual && ex_target != ex_pred_target));
    assign ex_hit  = tbl_q[ex_idx].valid && tbl_q[ex_idx].tag == ex_tag;
    assign wr_en   = resolve && (actual || ex_hit);

    always_comb begin
        pc_sel      = 1'b0;
        redirect_pc = '0;
        if (reset) begin
            pc_sel      = 1'b0;
            redirect_pc = '0;
        end else if (halt) begin
            pc_sel      = 1'b1;
            redirect_pc = ex_pc32;
        end else if (mispred) begin
            pc_sel      = 1'b1;
            redirect_pc = actual ? ex_target : ex_pc32 + 32'd4;
        end
    end

    sat_counter #(
        .CTR_W (CTR_W)
    ) u_ctr (
        .ctr_i   (tbl_q[ex_idx].ctr[CTR_W-1:0]),
        .hit_i   (ex_hit),
        .jal_i   (ex_jal),
        .taken_i (actual),
        .ctr_o   (ctr_nxt)
    );

    always_comb begin
        ent_d        = tbl_q[ex_idx];
        ent_d.valid  = 1'b1;
        ent_d.tag    = ex_tag;
        ent_d.ctr    = CTR_W_MAX'(ctr_nxt);
        if (actual) ent_d.target = ex_target;
        br_d  = (resolve && br_q != 16'hFFFF) ? br_q + 16'd1 : br_q;
        mis_d = (mispred && mis_q != 16'hFFFF) ? mis_q + 16'd1 : mis_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].ctr    <= WEAK_NT;
                tbl_q[i].target <= '0;
            end
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            if (wr_en) tbl_q[ex_idx] <= ent_d;
            br_q  <= br_d;
            mis_q <= mis_d;
        end
    end

    assign br_count  = br_q;
    assign mis_count = mis_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit
// using the default 9-bit PC, 16-entry, 2-bit-counter configuration.
module tb_branch_predict_unit;

    logic        clk;
    logic        reset;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic        ex_branch;
    logic        ex_jal;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        halt;
    logic        pc_sel;
    logic [31:0] redirect_pc;
    logic [15:0] br_count;
    logic [15:0] mis_count;

    int ncmp = 0;
    int nbad = 0;

    branch_predict_unit dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .halt           (halt),
        .pc_sel         (pc_sel),
        .redirect_pc    (redirect_pc),
        .br_count       (br_count),
        .mis_count      (mis_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ex_valid       = 1'b0;
        ex_pc          = '0;
        ex_branch      = 1'b0;
        ex_jal         = 1'b0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
        halt           = 1'b0;
    endtask

    task automatic ex_op(input logic jal, input logic [8:0] pc,
                         input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_branch      = !jal;
        ex_jal         = jal;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic look(input string tag, input logic [8:0] pc,
                        input logic tk, input logic [31:0] tgt);
        if_pc = pc;
        #1;
        check({tag, ".tk"}, 32'(pred_taken), 32'(tk));
        check({tag, ".tgt"}, pred_target, tgt);
    endtask

    task automatic redir(input string tag, input logic sel,
                         input logic [31:0] pc);
        #1;
        check({tag, ".sel"}, 32'(pc_sel), 32'(sel));
        check({tag, ".rpc"}, redirect_pc, pc);
    endtask

    task automatic counts(input string tag, input int b, input int m);
        check({tag, ".br"}, 32'(br_count), 32'(b));
        check({tag, ".mis"}, 32'(mis_count), 32'(m));
    endtask

    initial begin
        reset = 1'b1;
        if_pc = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        look("rst", 9'h040, 1'b0, 32'h44);
        counts("rst", 0, 0);
        redir("rst", 1'b0, 32'h0);

        // first taken resolve allocates weakly taken; same-cycle lookup sees old state
        ex_op(1'b0, 9'h040, 1'b1, 32'h10, 1'b0, 32'h44);
        redir("br1", 1'b1, 32'h10);
        look("br1.pre", 9'h040, 1'b0, 32'h44);
        tick();
        idle();
        look("br1.post", 9'h040, 1'b1, 32'h10);
        counts("br1", 1, 1);

        ex_op(1'b0, 9'h040, 1'b0, 32'h10, 1'b1, 32'h10);
        redir("nt1", 1'b1, 32'h44);
        tick();
        idle();
        look("nt1.post", 9'h040, 1'b0, 32'h44);

        ex_op(1'b0, 9'h040, 1'b0, 32'h10, 1'b0, 32'h44);
        redir("nt2", 1'b0, 32'h0);
        tick();
        idle();
        look("nt2.post", 9'h040, 1'b0, 32'h44);
        counts("nt2", 3, 2);

        // counter at 0: one taken only reaches 1, a second reaches 2
        ex_op(1'b0, 9'h040, 1'b1, 32'h10, 1'b0, 32'h44);
        tick();
        idle();
        look("tk1.post", 9'h040, 1'b0, 32'h44);
        ex_op(1'b0, 9'h040, 1'b1, 32'h10, 1'b0, 32'h44);
        tick();
        idle();
        look("tk2.post", 9'h040, 1'b1, 32'h10);
        counts("tk2", 5, 4);

        ex_op(1'b1, 9'h020, 1'b0, 32'h100, 1'b0, 32'h24);
        halt = 1'b1;
        redir("halt", 1'b1, 32'h20);
        tick();
        idle();
        look("halt.post", 9'h020, 1'b0, 32'h24);
        counts("halt", 5, 4);

        ex_op(1'b1, 9'h020, 1'b0, 32'h100, 1'b0, 32'h24);
        redir("jal1", 1'b1, 32'h100);
        tick();
        idle();
        look("jal1.post", 9'h020, 1'b1, 32'h100);

        ex_op(1'b1, 9'h020, 1'b0, 32'h100, 1'b1, 32'h104);
        redir("jalt", 1'b1, 32'h100);
        ex_pred_target = 32'h100;
        redir("jalok", 1'b0, 32'h0);
        tick();
        idle();
        counts("jal", 7, 5);

        // 0x080 shares idx 0 with 0x040 but carries a different tag
        ex_op(1'b0, 9'h080, 1'b1, 32'h30, 1'b0, 32'h84);
        tick();
        idle();
        look("alias.40", 9'h040, 1'b0, 32'h44);
        look("alias.80", 9'h080, 1'b1, 32'h30);

        ex_op(1'b0, 9'h0C0, 1'b0, 32'h50, 1'b0, 32'hC4);
        redir("ntmiss", 1'b0, 32'h0);
        tick();
        idle();
        look("ntmiss.80", 9'h080, 1'b1, 32'h30);
        look("ntmiss.c0", 9'h0C0, 1'b0, 32'hC4);
        counts("ntmiss", 9, 6);

        ex_op(1'b0, 9'h104, 1'b0, 32'h0, 1'b1, 32'h108);
        for (int i = 0; i < 65540; i++) tick();
        idle();
        #1;
        counts("sat", 65535, 65535);

        if_pc = 9'h080;
        ex_op(1'b0, 9'h040, 1'b1, 32'h10, 1'b0, 32'h44);
        halt = 1'b1;
        #1;
        check("prerst.tk", 32'(pred_taken), 32'd1);
        check("prerst.sel", 32'(pc_sel), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst.tk", 32'(pred_taken), 32'd0);
        check("midrst.tgt", pred_target, 32'h84);
        check("midrst.sel", 32'(pc_sel), 32'd0);
        check("midrst.rpc", redirect_pc, 32'h0);
        counts("midrst", 0, 0);
        tick();
        reset = 1'b0;
        idle();
        look("postrst", 9'h080, 1'b0, 32'h84);
        counts("postrst", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning the program-counter width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning the table entry count; it SHALL be a power of two, with PC_W >= log2(ENTRIES)+3.
REQ-003 SHALL have parameter CTR_W, default 2, meaning the saturating-counter width; range 1..4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port if_pc, input, PC_W bits: the fetch-stage PC to look up.
REQ-007 SHALL have port pred_taken, output, 1 bit: predict taken for if_pc.
REQ-008 SHALL have port pred_target, output, 32 bits: the predicted target, zero-extended.
REQ-009 SHALL have port ex_valid, input, 1 bit: the EX stage holds a valid instruction.
REQ-010 SHALL have port ex_pc, input, PC_W bits: the PC of the EX instruction.
REQ-011 SHALL have port ex_branch / ex_jal, inputs, 1 bit each: the EX instruction is a conditional branch / a jump.
REQ-012 SHALL have port ex_taken, input, 1 bit: the resolved condition, i.e. ALU compare result.
REQ-013 SHALL have port ex_target, input, 32 bits: the resolved target (PC+Imm or ALU result for jalr).
REQ-014 SHALL have ports ex_pred_taken / ex_pred_target, inputs, 1 / 32 bits: the prediction carried down the pipe with the instruction.
REQ-015 SHALL have port halt, input, 1 bit: freeze the pipeline at ex_pc.
REQ-016 SHALL have ports pc_sel, output, 1 bit, and redirect_pc, output, 32 bits: fetch-redirect request and its address.
REQ-017 SHALL have ports br_count / mis_count, outputs, 16 bits each: resolved control-transfer count and mispredict count.

Function
REQ-018 SHALL derive idx = pc[log2(ENTRIES)+1:2] and tag = pc[PC_W-1:log2(ENTRIES)+2]; each entry SHALL hold valid, tag, CTR_W-bit counter and 32-bit target.
REQ-019 SHALL compute the lookup combinationally from if_pc, with zero latency: pred_taken = valid && tag match && counter MSB; pred_target = the entry target when pred_taken, else if_pc+4.
REQ-020 SHALL define resolve = ex_valid && (ex_branch || ex_jal) && !halt, and actual = ex_jal || (ex_branch && ex_taken).
REQ-021 SHALL flag a mispredict, combinationally, when resolve && (actual != ex_pred_taken || (actual && ex_target != ex_pred_target)).
REQ-022 SHALL drive, on a mispredict, pc_sel=1 and redirect_pc = actual ? ex_target : ex_pc+4; otherwise pc_sel=0 and redirect_pc=0.
REQ-023 SHALL, when halt=1, drive pc_sel=1 and redirect_pc=ex_pc zero-extended, with no table or counter update; halt overrides every other condition.
REQ-024 SHALL, on resolve at the clock edge, write the entry at idx(ex_pc): set valid, write tag and write target=ex_target when actual.
REQ-025 SHALL, on a tag miss with actual=0, leave the entry unallocated.
REQ-026 SHALL update the counter as follows: ex_jal sets it to max; a branch with a tag hit increments on taken, saturating at 2^CTR_W-1, and decrements on not-taken, saturating at 0.
REQ-027 SHALL set the counter to weakly-taken (2^(CTR_W-1)) on a new allocation by a conditional branch.
REQ-028 SHALL, when a lookup and an update hit the same index in the same cycle, return the pre-update state on the lookup, with no bypass.
REQ-029 SHALL increment br_count on each resolve and mis_count on each mispredict, each saturating at 16'hFFFF.
REQ-030 SHALL compute PC arithmetic in 32 bits with the PC zero-extended and carries discarded.

Reset
REQ-031 SHALL, on reset, immediately clear all valid bits, set all counters to weakly-not-taken (2^(CTR_W-1)-1) and clear all targets, tags, br_count and mis_count.
REQ-032 SHALL, while reset is asserted, drive pred_taken=0, pred_target=if_pc+4, and pc_sel=0 with redirect_pc=0 regardless of halt.
REQ-033 SHALL discard any update in flight when reset is asserted mid-operation.

Structure
REQ-034 SHALL place the entry struct typedef, the counter max/weak constants and the idx/tag width functions in package branch_predict_pkg.
REQ-035 SHALL implement the counter next-state logic as sub-module sat_counter, parameterised by CTR_W; the table and lookup SHALL stay in the top.

Verification
REQ-036 SHALL cover: after reset, if_pc=0x040 -> pred_taken=0, pred_target=0x044, and br_count=mis_count=0.
REQ-037 SHALL cover: a branch at ex_pc=0x040 with ex_taken=1, target 0x010 and pred_taken=0 -> pc_sel=1, redirect 0x010; next cycle if_pc=0x040 -> pred_taken=1, pred_target=0x010.
REQ-038 SHALL cover: the same branch resolved not-taken twice after one taken resolve -> counter goes 2 to 1 to 0 and pred_taken=0; the first not-taken redirects to 0x044.
REQ-039 SHALL cover: jal at 0x020 with target 0x100 and halt=1 -> pc_sel=1, redirect 0x020, and no table change or count change.
REQ-040 SHALL cover: branch 0x040 followed by branch 0x080, which aliases to idx 0 with ENTRIES=16 -> tag mismatch, so a lookup of 0x040 gives pred_taken=0.
REQ-041 SHALL cover: 65540 mispredicts -> mis_count holds 0xFFFF; reset asserted mid-cycle -> all outputs at reset values before the next edge.
